// File: rtl/display_saida.sv
// Serial double-dabble binary-to-BCD converter feeding a 4-digit multiplexed
// 7-segment display (sign, hundreds, tens, units) with leading-zero blanking.
module display_saida #(
  parameter int DIV_REFRESH = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] valor,
  input  logic       modo_sinal,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       pronto
);

  typedef enum logic [1:0] {OCIOSO, CONVERTE, CARREGA} estado_t;

  localparam int CW = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;
  localparam logic [CW-1:0] REF_MAX = CW'(DIV_REFRESH - 1);

  estado_t       r_estado, w_prox;
  logic [8:0]    r_ultimo;
  logic [19:0]   r_sr;
  logic [2:0]    r_cnt;
  logic          r_neg_tmp;
  logic [3:0]    r_dig_u, r_dig_d, r_dig_c;
  logic          r_negativo;
  logic [CW-1:0] r_ref;
  logic [1:0]    r_idx;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  logic          w_mudou;
  logic          w_neg;
  logic [7:0]    w_mag;
  logic [19:0]   w_sr_adj;
  logic [6:0]    w_seg;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign w_mudou  = ({modo_sinal, valor} != r_ultimo);
  assign w_neg    = modo_sinal & valor[7];
  // 8'h80 negates to itself, which is exactly 128 as an unsigned magnitude
  assign w_mag    = w_neg ? (~valor + 8'd1) : valor;
  assign w_sr_adj = {add3(r_sr[19:16]), add3(r_sr[15:12]), add3(r_sr[11:8]), r_sr[7:0]};
  assign pronto   = (r_estado == OCIOSO);

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO:   if (w_mudou) w_prox = CONVERTE;
      CONVERTE: if (r_cnt == 3'd7) w_prox = CARREGA;
      CARREGA:  w_prox = OCIOSO;
      default:  w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_estado <= OCIOSO;
    else     r_estado <= w_prox;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ultimo   <= 9'd0;
      r_cnt      <= 3'd0;
      r_dig_u    <= 4'd0;
      r_dig_d    <= 4'd0;
      r_dig_c    <= 4'd0;
      r_negativo <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (w_mudou) begin
            r_ultimo  <= {modo_sinal, valor};
            r_sr      <= {12'd0, w_mag};
            r_cnt     <= 3'd0;
            r_neg_tmp <= w_neg;
          end
        end
        CONVERTE: begin
          r_sr  <= w_sr_adj << 1;
          r_cnt <= r_cnt + 3'd1;
        end
        CARREGA: begin
          r_dig_c    <= r_sr[19:16];
          r_dig_d    <= r_sr[15:12];
          r_dig_u    <= r_sr[11:8];
          r_negativo <= r_neg_tmp;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_seg = 7'h7F;
    case (r_idx)
      2'd0: w_seg = enc(r_dig_u);
      2'd1: w_seg = ((r_dig_c == 4'd0) && (r_dig_d == 4'd0)) ? 7'h7F : enc(r_dig_d);
      2'd2: w_seg = (r_dig_c == 4'd0) ? 7'h7F : enc(r_dig_c);
      2'd3: w_seg = r_negativo ? 7'h3F : 7'h7F;
      default: w_seg = 7'h7F;
    endcase
  end

  // Scan: an and seg are registered together so they always agree on the digit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref <= '0;
      r_idx <= 2'd0;
      r_an  <= 4'b1110;
      r_seg <= 7'h40;
    end else begin
      if (r_ref == REF_MAX) begin
        r_ref <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_ref <= r_ref + 1'b1;
      end
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_seg;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_display_saida.sv
// Randomized bench for display_saida: displayed digits are predicted from the
// decimal value of the inputs and checked on every scanned digit.
module tb_display_saida;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] valor;
  logic       modo_sinal;
  logic [6:0] seg;
  logic [3:0] an;
  logic       pronto;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_v = 0;
  int cur_m = 0;
  int tbl[10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

  display_saida #(.DIV_REFRESH(2)) dut (
    .clk(clk), .rst(rst), .valor(valor), .modo_sinal(modo_sinal),
    .seg(seg), .an(an), .pronto(pronto)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int exp_seg(input int pos, input int v, input int m);
    int mag;
    bit neg;
    neg = (m != 0) && (v >= 128);
    mag = neg ? 256 - v : v;
    case (pos)
      0: return tbl[mag % 10];
      1: return (mag < 10) ? 'h7F : tbl[(mag / 10) % 10];
      2: return (mag < 100) ? 'h7F : tbl[mag / 100];
      default: return neg ? 'h3F : 'h7F;
    endcase
  endfunction

  function automatic int pos_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic seg_now(input string tag, input int v, input int m);
    int p;
    p = pos_of(an);
    chk({tag, "_an"}, int'(p >= 0), 1);
    if (p >= 0) chk(tag, int'(seg), exp_seg(p, v, m));
  endtask

  task automatic check_display(input int v, input int m);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seg_now("disp", v, m);
    end
  endtask

  // pre = number of busy samples already observed since the change was taken
  task automatic wait_conv(input int ov, input int om, input int nv, input int nm, input int pre);
    int n;
    n = pre;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pronto) break;
      n++;
      seg_now("hold", ov, om);
    end
    chk("busy_len", n, 9);
    seg_now("last_old", ov, om);
    @(negedge clk);
    seg_now("new", nv, nm);
  endtask

  task automatic apply(input int v, input int m);
    valor = 8'(v);
    modo_sinal = 1'(m);
    wait_conv(cur_v, cur_m, v, m, 0);
    cur_v = v;
    cur_m = m;
  endtask

  initial begin
    int rv, rm;
    rst = 1'b1;
    valor = 8'd0;
    modo_sinal = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pronto", int'(pronto), 1);
    chk("rst_an", int'(an), 'hE);
    chk("rst_seg", int'(seg), 'h40);
    rst = 1'b0;

    // scan order after reset with a zero value: units shown, others blank
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("scan_an", int'(an), int'(~(4'b0001 << (((k - 1) / 2) % 4))) & 'hF);
      chk("scan_seg", int'(seg), exp_seg(((k - 1) / 2) % 4, 0, 0));
      chk("idle_pronto", int'(pronto), 1);
    end

    apply(123, 0);  check_display(123, 0);
    apply(255, 1);  check_display(255, 1);
    apply(255, 0);  check_display(255, 0);
    apply(128, 1);  check_display(128, 1);
    apply(7, 0);    check_display(7, 0);

    // change during conversion is ignored, then picked up afterwards
    apply(55, 0);
    valor = 8'd10;
    modo_sinal = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_busy", int'(pronto), 0);
    end
    valor = 8'd200;
    wait_conv(cur_v, cur_m, 10, 0, 3);
    wait_conv(10, 0, 200, 0, 1);
    cur_v = 200;
    cur_m = 0;
    check_display(200, 0);

    // reset mid-conversion discards it; held input reconverts afterwards
    apply(5, 0);
    valor = 8'd99;
    modo_sinal = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pronto", int'(pronto), 1);
    chk("mid_rst_an", int'(an), 'hE);
    chk("mid_rst_seg", int'(seg), 'h40);
    rst = 1'b0;
    wait_conv(0, 0, 99, 0, 0);
    cur_v = 99;
    cur_m = 0;
    check_display(99, 0);

    for (int i = 0; i < 24; i++) begin
      rv = int'($urandom_range(0, 255));
      rm = int'($urandom_range(0, 1));
      if (rv == cur_v && rm == cur_m) rv = rv ^ 1;
      apply(rv, rm);
      check_display(rv, rm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
